// File: rtl/lpddr3_dqs_delay_trainer.sv
// DQS read-capture centring controller: walks the IOD delay line one tap at a time
// under eye-monitor EARLY/LATE guidance until CENTER_HITS clean decisions are seen.
module lpddr3_dqs_delay_trainer #(
  parameter int unsigned TAP_W       = 8,
  parameter int unsigned LOAD_TAP    = 1,
  parameter int unsigned MAX_TAP     = 255,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned SAMPLE_CYC  = 16,
  parameter int unsigned MOVE_GAP    = 4,
  parameter int unsigned CENTER_HITS = 3,
  parameter int unsigned MAX_ITER    = 512,
  localparam int unsigned STEP_W     = $clog2(MAX_ITER + 1)
) (
  input  logic              FAB_CLK,
  input  logic              SYNC_RST,
  input  logic              START,
  input  logic              EYE_MONITOR_EARLY,
  input  logic              EYE_MONITOR_LATE,
  input  logic              DELAY_LINE_OUT_OF_RANGE,
  output logic              DELAY_LINE_LOAD,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_DIRECTION,
  output logic              EYE_MONITOR_CLEAR_FLAGS,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [TAP_W-1:0]  TAP_POS,
  output logic [STEP_W-1:0] STEP_CNT
);

  // One shared down-counter covers settle, sample and the move-pulse-plus-gap window.
  localparam int unsigned CNT_MAX_A = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > MOVE_GAP + 1) ? CNT_MAX_A : MOVE_GAP + 1;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);
  localparam int unsigned HIT_W     = $clog2(CENTER_HITS + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, CLEAR, SETTLE, SAMPLE, DECIDE, STEP, GAP, DONE_S, FAIL_S
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [HIT_W-1:0]    hits, hits_n;
  logic                acc_e, acc_e_n, acc_l, acc_l_n;
  logic                dir_n, move_n, busy_s, busy_n;
  logic [TAP_W-1:0]    tap_n;
  logic [STEP_W-1:0]   step_n, step_inc;

  assign busy_s = (state != IDLE) && (state != DONE_S) && (state != FAIL_S);

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      state                   <= IDLE;
      cnt                     <= '0;
      hits                    <= '0;
      acc_e                   <= 1'b0;
      acc_l                   <= 1'b0;
      DELAY_LINE_LOAD         <= 1'b0;
      DELAY_LINE_MOVE         <= 1'b0;
      DELAY_LINE_DIRECTION    <= 1'b0;
      EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
      BUSY                    <= 1'b0;
      DONE                    <= 1'b0;
      FAIL                    <= 1'b0;
      TAP_POS                 <= TAP_W'(LOAD_TAP);
      STEP_CNT                <= '0;
    end else begin
      state                   <= state_n;
      cnt                     <= cnt_n;
      hits                    <= hits_n;
      acc_e                   <= acc_e_n;
      acc_l                   <= acc_l_n;
      DELAY_LINE_LOAD         <= (state_n == LOAD);
      DELAY_LINE_MOVE         <= move_n;
      DELAY_LINE_DIRECTION    <= dir_n;
      EYE_MONITOR_CLEAR_FLAGS <= (state_n == CLEAR);
      BUSY                    <= busy_n;
      DONE                    <= (state_n == DONE_S);
      FAIL                    <= (state_n == FAIL_S);
      TAP_POS                 <= tap_n;
      STEP_CNT                <= step_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hits_n   = hits;
    acc_e_n  = acc_e;
    acc_l_n  = acc_l;
    dir_n    = DELAY_LINE_DIRECTION;
    move_n   = 1'b0;
    tap_n    = TAP_POS;
    step_n   = STEP_CNT;
    step_inc = (STEP_CNT == STEP_W'(MAX_ITER)) ? STEP_CNT : STEP_CNT + STEP_W'(1);

    unique case (state)
      IDLE, DONE_S, FAIL_S: begin
        if (START) begin
          state_n = LOAD;
          tap_n   = TAP_W'(LOAD_TAP);
          step_n  = '0;
          hits_n  = '0;
        end
      end
      LOAD: state_n = CLEAR;
      CLEAR: begin
        acc_e_n = 1'b0;
        acc_l_n = 1'b0;
        cnt_n   = CNT_W'(SETTLE_CYC - 1);
        state_n = SETTLE;
      end
      SETTLE: begin
        if (cnt == '0) begin
          cnt_n   = CNT_W'(SAMPLE_CYC - 1);
          state_n = SAMPLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      SAMPLE: begin
        acc_e_n = acc_e | EYE_MONITOR_EARLY;
        acc_l_n = acc_l | EYE_MONITOR_LATE;
        if (cnt == '0) state_n = DECIDE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      DECIDE: begin
        step_n = step_inc;
        if (!acc_e && !acc_l) begin
          hits_n  = hits + HIT_W'(1);
          state_n = (hits == HIT_W'(CENTER_HITS - 1)) ? DONE_S : CLEAR;
        end else begin
          hits_n = '0;
          if (acc_e ^ acc_l) begin
            dir_n   = acc_e;
            state_n = STEP;
          end else begin
            state_n = CLEAR;
          end
        end
        // Iteration limit loses only to a successful centre.
        if (state_n != DONE_S && step_inc == STEP_W'(MAX_ITER)) state_n = FAIL_S;
      end
      STEP: begin
        if ((DELAY_LINE_DIRECTION && TAP_POS == TAP_W'(MAX_TAP)) ||
            (!DELAY_LINE_DIRECTION && TAP_POS == '0)) begin
          state_n = FAIL_S;
        end else begin
          move_n  = 1'b1;
          tap_n   = DELAY_LINE_DIRECTION ? TAP_POS + TAP_W'(1) : TAP_POS - TAP_W'(1);
          cnt_n   = CNT_W'(MOVE_GAP);
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == '0) state_n = CLEAR;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase

    // Delay-line limit aborts the run from any active state, freezing the readout.
    if (busy_s && DELAY_LINE_OUT_OF_RANGE) begin
      state_n = FAIL_S;
      move_n  = 1'b0;
      tap_n   = TAP_POS;
      step_n  = STEP_CNT;
      dir_n   = DELAY_LINE_DIRECTION;
    end

    busy_n = (state_n != IDLE) && (state_n != DONE_S) && (state_n != FAIL_S);
  end

endmodule
